// File: rtl/sel_scan_pkg.sv
// Shared types and constants for the select-line scan sequencer.
package sel_scan_pkg;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned DWELL_MAX = 255;
  localparam int unsigned DWELL_W   = $clog2(DWELL_MAX + 1);

  // Lowest enabled line when ascending, highest when descending.
  function automatic logic [SEL_W-1:0] first_line(input logic [NUM_LINES-1:0] m,
                                                  input logic                 d);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] ii;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_LINES; k++) begin
      ii = d ? SEL_W'(NUM_LINES - 1 - k) : SEL_W'(k);
      if (!found && m[ii]) begin
        idx   = ii;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/sel_scan_sequencer_next.sv
// Combinational next-enabled-line search in the latched scan direction.
module sel_scan_next
  import sel_scan_pkg::*;
(
  input  logic [NUM_LINES-1:0] mask,
  input  logic [SEL_W-1:0]     cur,
  input  logic                 dir,
  output logic [SEL_W-1:0]     nxt,
  output logic                 last
);

  logic [SEL_W-1:0] ii;

  always_comb begin
    nxt  = cur;
    last = 1'b1;
    ii   = '0;
    // Walking away from cur, the first hit is the nearest enabled line.
    for (int unsigned k = 0; k < NUM_LINES; k++) begin
      ii = dir ? SEL_W'(NUM_LINES - 1 - k) : SEL_W'(k);
      if (last && mask[ii] && (dir ? (ii < cur) : (ii > cur))) begin
        nxt  = ii;
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sel_scan_sequencer.sv
// Scan sequencer driving the 3-to-8 decoder selects.
// Build option: define SEL_SCAN_LOOP_EN to rescan continuously instead of stopping after one pass.
module sel_scan_sequencer
  import sel_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 dir,
  input  logic [NUM_LINES-1:0] mask,
  output logic [SEL_W-1:0]     sel,
  output logic                 sel_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     pass_cnt
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     sel_nxt;
  logic [DWELL_W-1:0]   cnt, cnt_nxt;
  logic [NUM_LINES-1:0] mask_q, mask_nxt;
  logic                 dir_q, dir_nxt;
  logic                 done_nxt, err_nxt;
  logic [CNT_W-1:0]     pass_nxt;
  logic [SEL_W-1:0]     step_idx;
  logic                 step_last;

  sel_scan_next u_next (
    .mask (mask_q),
    .cur  (sel),
    .dir  (dir_q),
    .nxt  (step_idx),
    .last (step_last)
  );

  assign sel_valid = (state == SCAN);
  assign busy      = (state == SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= '0;
      cnt      <= '0;
      mask_q   <= '0;
      dir_q    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      pass_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      cnt      <= cnt_nxt;
      mask_q   <= mask_nxt;
      dir_q    <= dir_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      pass_cnt <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    mask_nxt  = mask_q;
    dir_nxt   = dir_q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    pass_nxt  = pass_cnt;
    unique case (state)
      IDLE: begin
        sel_nxt = '0;
        cnt_nxt = '0;
        if (start && (mask == '0)) begin
          err_nxt = 1'b1;
        end else if (start && !stop) begin
          mask_nxt  = mask;
          dir_nxt   = dir;
          sel_nxt   = first_line(mask, dir);
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (stop) begin
          state_nxt = IDLE;
          sel_nxt   = '0;
          cnt_nxt   = '0;
        end else if (cnt == DWELL_LAST) begin
          cnt_nxt = '0;
          if (step_last) begin
            done_nxt = 1'b1;
            pass_nxt = pass_cnt + CNT_W'(1);
`ifdef SEL_SCAN_LOOP_EN
            sel_nxt  = first_line(mask_q, dir_q);
`else
            sel_nxt   = '0;
            state_nxt = IDLE;
`endif
          end else begin
            sel_nxt = step_idx;
          end
        end else begin
          cnt_nxt = cnt + DWELL_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
